// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster-scan timing generator for the pixel renderers.
//   Produces the pixel coordinates (DrawX/DrawY), the active-video flag,
//   active-low horizontal/vertical syncs and per-line / per-frame ticks.
//   The timing parameters must keep H_TOTAL and V_TOTAL at or below 1024.
// Ports:
//   vga_clk    in   pixel-domain clock
//   reset      in   synchronous, active-high reset
//   ce         in   pixel clock enable; counters advance only when 1
//   DrawX      out  horizontal count, 0..H_TOTAL-1
//   DrawY      out  vertical count, 0..V_TOTAL-1
//   blank      out  1 = active video; forced 0 while reset is held
//   hs         out  horizontal sync, active-low
//   vs         out  vertical sync, active-low (also the frame_clk)
//   line_tick  out  pulse on the last pixel of each line (ce=1 cycles only)
//   frame_tick out  pulse on the last pixel of each frame (ce=1 cycles only)
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int unsigned CW           = 10;
  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          active_q, active_d;
  logic          h_last;
  logic          v_last;

  // Last pixel of the line / last line of the frame, from the current counters.
  assign h_last = (hc_q == CW'(H_TOTAL - 1));
  assign v_last = (vc_q == CW'(V_TOTAL - 1));

  // Next counter values, and sync/active decoded from them so the registered
  // flags line up with the registered coordinates on the same cycle.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (ce) begin
      if (h_last) begin
        hc_d = '0;
        vc_d = v_last ? '0 : vc_q + CW'(1);
      end else begin
        hc_d = hc_q + CW'(1);
      end
    end
    hs_d     = !((hc_d >= CW'(H_SYNC_START)) && (hc_d < CW'(H_SYNC_END)));
    vs_d     = !((vc_d >= CW'(V_SYNC_START)) && (vc_d < CW'(V_SYNC_END)));
    active_d = (hc_d < CW'(H_VISIBLE)) && (vc_d < CW'(V_VISIBLE));
  end

  // State registers. Reset loads the decode of position (0,0): syncs idle
  // and active set, so video starts on the first cycle after release.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_q     <= '0;
      vc_q     <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      active_q <= 1'b1;
    end else begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      active_q <= active_d;
    end
  end

  assign DrawX = hc_q;
  assign DrawY = vc_q;
  assign hs    = hs_q;
  assign vs    = vs_q;

  // Renderers must stay dark for as long as reset is asserted.
  assign blank = active_q & ~reset;

  // Ticks qualify with ce so they mark only cycles on which the counters move.
  assign line_tick  = ce & ~reset & h_last;
  assign frame_tick = line_tick & v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a full-size instance (640x480 timing) and a
// reduced-size instance (64x48 timing) share clock, reset and ce, so that
// whole-frame behaviour fits into a short run. The reference model tracks
// each raster as a linear pixel index and derives all outputs from it.
module tb_vga_timing_gen;

  localparam int S_HV = 64;
  localparam int S_HF = 4;
  localparam int S_HS = 8;
  localparam int S_HB = 4;
  localparam int S_VV = 48;
  localparam int S_VF = 3;
  localparam int S_VS = 2;
  localparam int S_VB = 5;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic       ce;
  logic [9:0] drawx [2];
  logic [9:0] drawy [2];
  logic       blank [2];
  logic       hs    [2];
  logic       vs    [2];
  logic       lt    [2];
  logic       ft    [2];

  int checks = 0;
  int errors = 0;

  int hv  [2] = '{640, S_HV};
  int hf  [2] = '{16,  S_HF};
  int hsw [2] = '{96,  S_HS};
  int hb  [2] = '{48,  S_HB};
  int vv  [2] = '{480, S_VV};
  int vf  [2] = '{10,  S_VF};
  int vsw [2] = '{2,   S_VS};
  int vb  [2] = '{33,  S_VB};
  int mx  [2] = '{0, 0};
  int my  [2] = '{0, 0};

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen u_dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .ce         (ce),
    .DrawX      (drawx[0]),
    .DrawY      (drawy[0]),
    .blank      (blank[0]),
    .hs         (hs[0]),
    .vs         (vs[0]),
    .line_tick  (lt[0]),
    .frame_tick (ft[0])
  );

  vga_timing_gen #(
    .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
  ) u_small (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .ce         (ce),
    .DrawX      (drawx[1]),
    .DrawY      (drawy[1]),
    .blank      (blank[1]),
    .hs         (hs[1]),
    .vs         (vs[1]),
    .line_tick  (lt[1]),
    .frame_tick (ft[1])
  );

  // ---------------- reference model ----------------
  function automatic int ht(int k);
    return hv[k] + hf[k] + hsw[k] + hb[k];
  endfunction

  function automatic int vt(int k);
    return vv[k] + vf[k] + vsw[k] + vb[k];
  endfunction

  function automatic logic e_blank(int k);
    return !reset && (mx[k] < hv[k]) && (my[k] < vv[k]);
  endfunction

  function automatic logic e_hs(int k);
    return !((mx[k] >= hv[k] + hf[k]) && (mx[k] < hv[k] + hf[k] + hsw[k]));
  endfunction

  function automatic logic e_vs(int k);
    return !((my[k] >= vv[k] + vf[k]) && (my[k] < vv[k] + vf[k] + vsw[k]));
  endfunction

  function automatic logic e_lt(int k);
    return ce && !reset && (mx[k] == ht(k) - 1);
  endfunction

  function automatic logic e_ft(int k);
    return e_lt(k) && (my[k] == vt(k) - 1);
  endfunction

  // One clock edge; the model follows the same reset/ce the DUTs sample.
  task automatic step();
    int idx;
    @(posedge vga_clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mx[k] = 0;
        my[k] = 0;
      end else if (ce) begin
        idx = my[k] * ht(k) + mx[k] + 1;
        if (idx == ht(k) * vt(k)) idx = 0;
        mx[k] = idx % ht(k);
        my[k] = idx / ht(k);
      end
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic c);
    reset = r;
    ce    = c;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1'b1, 1'b1);
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      checks += 7;
      if (drawx[k] !== 10'd0) begin errors++; $display("FAIL rst_drawx k=%0d got %0d exp 0", k, drawx[k]); end
      if (drawy[k] !== 10'd0) begin errors++; $display("FAIL rst_drawy k=%0d got %0d exp 0", k, drawy[k]); end
      if (blank[k] !== 1'b0)  begin errors++; $display("FAIL rst_blank k=%0d got %b exp 0", k, blank[k]); end
      if (hs[k] !== 1'b1)     begin errors++; $display("FAIL rst_hs k=%0d got %b exp 1", k, hs[k]); end
      if (vs[k] !== 1'b1)     begin errors++; $display("FAIL rst_vs k=%0d got %b exp 1", k, vs[k]); end
      if (lt[k] !== 1'b0)     begin errors++; $display("FAIL rst_line_tick k=%0d got %b exp 0", k, lt[k]); end
      if (ft[k] !== 1'b0)     begin errors++; $display("FAIL rst_frame_tick k=%0d got %b exp 0", k, ft[k]); end
    end
    drive(1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks += 3;
      if (drawx[k] !== 10'd0) begin errors++; $display("FAIL rel_drawx k=%0d got %0d exp 0", k, drawx[k]); end
      if (drawy[k] !== 10'd0) begin errors++; $display("FAIL rel_drawy k=%0d got %0d exp 0", k, drawy[k]); end
      if (blank[k] !== 1'b1)  begin errors++; $display("FAIL rel_blank k=%0d got %b exp 1", k, blank[k]); end
    end
  endtask

  task automatic test_line();
    int hs_low = 0, hs_first = -1, lt_cnt = 0, lt_x = -1;
    for (int c = 0; c < 800; c++) begin
      drive(1'b0, 1'b1);
      checks += 4;
      if (drawx[0] !== 10'(mx[0])) begin errors++; $display("FAIL line_drawx c=%0d got %0d exp %0d", c, drawx[0], mx[0]); end
      if (blank[0] !== e_blank(0)) begin errors++; $display("FAIL line_blank c=%0d got %b exp %b", c, blank[0], e_blank(0)); end
      if (hs[0] !== e_hs(0))       begin errors++; $display("FAIL line_hs c=%0d got %b exp %b", c, hs[0], e_hs(0)); end
      if (lt[0] !== e_lt(0))       begin errors++; $display("FAIL line_tick c=%0d got %b exp %b", c, lt[0], e_lt(0)); end
      if (c == 639) begin
        checks++;
        if (blank[0] !== 1'b1) begin errors++; $display("FAIL blank_639 got %b exp 1", blank[0]); end
      end
      if (c == 640) begin
        checks++;
        if (blank[0] !== 1'b0) begin errors++; $display("FAIL blank_640 got %b exp 0", blank[0]); end
      end
      if (hs[0] === 1'b0) begin
        if (hs_first < 0) hs_first = int'(drawx[0]);
        hs_low++;
      end
      if (lt[0] === 1'b1) begin
        lt_cnt++;
        lt_x = int'(drawx[0]);
      end
      step();
    end
    drive(1'b0, 1'b1);
    checks += 6;
    if (hs_low !== 96)       begin errors++; $display("FAIL hs_width got %0d exp 96", hs_low); end
    if (hs_first !== 656)    begin errors++; $display("FAIL hs_start got %0d exp 656", hs_first); end
    if (lt_cnt !== 1)        begin errors++; $display("FAIL line_tick_count got %0d exp 1", lt_cnt); end
    if (lt_x !== 799)        begin errors++; $display("FAIL line_tick_x got %0d exp 799", lt_x); end
    if (drawx[0] !== 10'd0)  begin errors++; $display("FAIL wrap_drawx got %0d exp 0", drawx[0]); end
    if (drawy[0] !== 10'd1)  begin errors++; $display("FAIL wrap_drawy got %0d exp 1", drawy[0]); end
  endtask

  task automatic test_ce_toggle();
    int hs_low = 0;
    for (int c = 0; c < 1600; c++) begin
      drive(1'b0, (c % 2) == 0);
      checks += 3;
      if (drawx[0] !== 10'(mx[0])) begin errors++; $display("FAIL tog_drawx c=%0d got %0d exp %0d", c, drawx[0], mx[0]); end
      if (lt[0] !== e_lt(0))       begin errors++; $display("FAIL tog_line_tick c=%0d got %b exp %b", c, lt[0], e_lt(0)); end
      if (hs[0] !== e_hs(0))       begin errors++; $display("FAIL tog_hs c=%0d got %b exp %b", c, hs[0], e_hs(0)); end
      if (hs[0] === 1'b0) hs_low++;
      step();
    end
    drive(1'b0, 1'b1);
    checks += 3;
    if (hs_low !== 192)     begin errors++; $display("FAIL tog_hs_width got %0d exp 192", hs_low); end
    if (drawx[0] !== 10'd0) begin errors++; $display("FAIL tog_end_drawx got %0d exp 0", drawx[0]); end
    if (drawy[0] !== 10'd2) begin errors++; $display("FAIL tog_end_drawy got %0d exp 2", drawy[0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);
      for (int k = 0; k < 2; k++) begin
        checks += 7;
        if (drawx[k] !== 10'(mx[k])) begin errors++; $display("FAIL rnd_drawx k=%0d c=%0d got %0d exp %0d", k, c, drawx[k], mx[k]); end
        if (drawy[k] !== 10'(my[k])) begin errors++; $display("FAIL rnd_drawy k=%0d c=%0d got %0d exp %0d", k, c, drawy[k], my[k]); end
        if (blank[k] !== e_blank(k)) begin errors++; $display("FAIL rnd_blank k=%0d c=%0d got %b exp %b", k, c, blank[k], e_blank(k)); end
        if (hs[k] !== e_hs(k))       begin errors++; $display("FAIL rnd_hs k=%0d c=%0d got %b exp %b", k, c, hs[k], e_hs(k)); end
        if (vs[k] !== e_vs(k))       begin errors++; $display("FAIL rnd_vs k=%0d c=%0d got %b exp %b", k, c, vs[k], e_vs(k)); end
        if (lt[k] !== e_lt(k))       begin errors++; $display("FAIL rnd_line_tick k=%0d c=%0d got %b exp %b", k, c, lt[k], e_lt(k)); end
        if (ft[k] !== e_ft(k))       begin errors++; $display("FAIL rnd_frame_tick k=%0d c=%0d got %b exp %b", k, c, ft[k], e_ft(k)); end
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    int budget = 0;
    drive(1'b1, 1'b1);
    step();
    drive(1'b0, 1'b1);
    while (!(mx[1] == 30 && my[1] == 20) && budget < 5000) begin
      step();
      budget++;
    end
    checks += 2;
    if (budget >= 5000) begin errors++; $display("FAIL mid_reach got timeout exp position 30,20"); end
    if (drawx[1] !== 10'd30 || drawy[1] !== 10'd20) begin
      errors++; $display("FAIL mid_pos got %0d,%0d exp 30,20", drawx[1], drawy[1]);
    end
    drive(1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (blank[k] !== 1'b0) begin errors++; $display("FAIL mid_blank_in_reset k=%0d got %b exp 0", k, blank[k]); end
    end
    step();
    drive(1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks += 5;
      if (drawx[k] !== 10'd0) begin errors++; $display("FAIL mid_drawx k=%0d got %0d exp 0", k, drawx[k]); end
      if (drawy[k] !== 10'd0) begin errors++; $display("FAIL mid_drawy k=%0d got %0d exp 0", k, drawy[k]); end
      if (blank[k] !== 1'b1)  begin errors++; $display("FAIL mid_blank_after k=%0d got %b exp 1", k, blank[k]); end
      if (hs[k] !== 1'b1)     begin errors++; $display("FAIL mid_hs k=%0d got %b exp 1", k, hs[k]); end
      if (vs[k] !== 1'b1)     begin errors++; $display("FAIL mid_vs k=%0d got %b exp 1", k, vs[k]); end
    end
  endtask

  task automatic test_frame();
    int vs_low = 0, blank_cnt = 0, bad_blank = 0, ft_cnt = 0;
    int ft_cyc [2] = '{-1, -1};
    int frame = S_HT * S_VT;
    drive(1'b1, 1'b1);
    step();
    for (int c = 0; c < 2 * frame; c++) begin
      drive(1'b0, 1'b1);
      checks += 5;
      if (drawx[1] !== 10'(mx[1])) begin errors++; $display("FAIL frm_drawx c=%0d got %0d exp %0d", c, drawx[1], mx[1]); end
      if (drawy[1] !== 10'(my[1])) begin errors++; $display("FAIL frm_drawy c=%0d got %0d exp %0d", c, drawy[1], my[1]); end
      if (vs[1] !== e_vs(1))       begin errors++; $display("FAIL frm_vs c=%0d got %b exp %b", c, vs[1], e_vs(1)); end
      if (ft[1] !== e_ft(1))       begin errors++; $display("FAIL frm_frame_tick c=%0d got %b exp %b", c, ft[1], e_ft(1)); end
      if (ft[1] === 1'b1 && lt[1] !== 1'b1) begin
        errors++; $display("FAIL frm_tick_pair c=%0d got line_tick %b exp 1", c, lt[1]);
      end
      if (vs[1] === 1'b0) vs_low++;
      if (blank[1] === 1'b1) begin
        blank_cnt++;
        if (drawx[1] >= 10'(S_HV) || drawy[1] >= 10'(S_VV)) bad_blank++;
      end
      if (ft[1] === 1'b1) begin
        if (ft_cnt < 2) ft_cyc[ft_cnt] = c;
        ft_cnt++;
      end
      step();
    end
    drive(1'b0, 1'b1);
    checks += 8;
    if (vs_low !== 2 * S_VS * S_HT)     begin errors++; $display("FAIL frm_vs_width got %0d exp %0d", vs_low, 2 * S_VS * S_HT); end
    if (blank_cnt !== 2 * S_HV * S_VV)  begin errors++; $display("FAIL frm_blank_count got %0d exp %0d", blank_cnt, 2 * S_HV * S_VV); end
    if (bad_blank !== 0)                begin errors++; $display("FAIL frm_blank_outside got %0d exp 0", bad_blank); end
    if (ft_cnt !== 2)                   begin errors++; $display("FAIL frm_tick_count got %0d exp 2", ft_cnt); end
    if (ft_cyc[0] !== frame - 1)        begin errors++; $display("FAIL frm_tick_first got %0d exp %0d", ft_cyc[0], frame - 1); end
    if (ft_cyc[1] - ft_cyc[0] !== frame) begin errors++; $display("FAIL frm_tick_period got %0d exp %0d", ft_cyc[1] - ft_cyc[0], frame); end
    if (drawx[1] !== 10'd0)             begin errors++; $display("FAIL frm_end_drawx got %0d exp 0", drawx[1]); end
    if (drawy[1] !== 10'd0)             begin errors++; $display("FAIL frm_end_drawy got %0d exp 0", drawy[1]); end
  endtask

  initial begin
    reset = 1'b1;
    ce    = 1'b0;
    test_reset();
    test_line();
    test_ce_toggle();
    test_random();
    test_mid_reset();
    test_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster scan that the background and sprite renderers consume: DrawX/DrawY pixel coordinates, the active-video flag, and horizontal/vertical syncs for the VGA DAC/HDMI encoder.
- Sources the per-frame tick used as frame_clk by scrolling and motion logic.
- Sits between the pixel clock domain root and all pixel-consuming renderers.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- Derived: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).

Ports:
- vga_clk  input  1  pixel-domain clock
- reset  input  1  synchronous, active-high reset
- ce  input  1  pixel clock enable; counters advance only on cycles with ce=1 (tie high when vga_clk is the pixel rate)
- DrawX  output  10  current horizontal count, 0..H_TOTAL-1
- DrawY  output  10  current vertical count, 0..V_TOTAL-1
- blank  output  1  1 = active video (DrawX<H_VISIBLE and DrawY<V_VISIBLE); renderers drive colour only when 1
- hs  output  1  horizontal sync, active-low
- vs  output  1  vertical sync, active-low; also used as frame_clk
- line_tick  output  1  one-cycle pulse on the last pixel of each line
- frame_tick  output  1  one-cycle pulse on the last pixel of each frame

Behaviour:
- Single clock, vga_clk. Reset is synchronous and active-high.
- Reset, sampled on a vga_clk edge, sets:
  - hc = 0, vc = 0.
  - blank forced 0 while reset is held.
  - hs = 1, vs = 1, line_tick = 0, frame_tick = 0.
- First cycle after reset release: DrawX=0, DrawY=0, blank=1.
- Counters hc and vc are registers. DrawX = hc and DrawY = vc directly, with no added latency.
- Counter advance, on vga_clk with ce=1 and reset=0:
  - hc = H_TOTAL-1 → hc wraps to 0.
    - If vc = V_TOTAL-1, vc wraps to 0; otherwise vc increments.
  - Otherwise hc increments and vc holds.
- ce=0: all counters and outputs hold their previous value. Ticks are deasserted.
- hs, vs, blank are decoded from the current hc/vc, so they are aligned to the same cycle as DrawX/DrawY. They are glitch-free because they are registered in parallel with the counters, computed from the next-state counter values.
  - hs = 0 iff H_VISIBLE+H_FRONT ≤ hc < H_VISIBLE+H_FRONT+H_SYNC, i.e. hc in 656..751.
  - vs = 0 iff V_VISIBLE+V_FRONT ≤ vc < V_VISIBLE+V_FRONT+V_SYNC, i.e. vc in 490..491. vs is low for whole lines, including hc across the line.
  - blank = 1 iff hc < H_VISIBLE and vc < V_VISIBLE.
- line_tick = 1 exactly when hc = H_TOTAL-1 and ce = 1.
- frame_tick = 1 exactly when hc = H_TOTAL-1, vc = V_TOTAL-1, and ce = 1.
- Simultaneous line_tick and frame_tick on the final pixel of a frame is required.
- Widths: 10-bit counters; comparisons are unsigned. Parameters must satisfy H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024.
- Reset mid-frame: counters return to 0,0 on the next edge with no partial-line completion; hs/vs go high immediately.
- Period: 800 × 525 = 420000 enabled cycles per frame (≈59.5 Hz at 25 MHz).

Test Plan:
- Reset then release, ce=1 → cycle 0: DrawX=0, DrawY=0, blank=1, hs=1, vs=1; cycle 639: blank=1; cycle 640: blank=0.
- Run one line, ce=1 → hs low for exactly 96 cycles starting at DrawX=656; line_tick high only at DrawX=799; next cycle DrawX=0, DrawY=1.
- Run a full frame → vs low for exactly 1600 enabled cycles (DrawY 490–491); frame_tick single pulse at (799,524); next cycle (0,0); frame_tick period 420000 cycles.
- ce toggled 1,0,1,0… → DrawX advances every other cycle; hs low width 192 vga_clk cycles; ticks asserted only on ce=1 cycles.
- Assert reset at DrawX=300, DrawY=200 for one cycle → next cycle DrawX=0, DrawY=0, blank=0 during reset, blank=1 the cycle after release.
- Count blank=1 cycles over one frame → exactly 307200; blank never 1 when DrawX≥640 or DrawY≥480.
